ntt_coef_loader: RTL



---
 rtl/ntt_coef_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/ntt_coef_loader.sv
// Serial coefficient loader for the NTT butterfly: reduces each coefficient mod p,
// optionally bit-reverses its slot, and commits rate-limited frames onto the poly bus.
module ntt_coef_loader #(
  parameter int p       = 17,
  parameter int N       = 8,
  parameter int logN    = $clog2(N),
  parameter int logP    = $clog2(p),
  parameter int Nb      = N * logP,
  parameter int IN_W    = 8,
  parameter int BITREV  = 0,
  parameter int MIN_GAP = 28
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] coef_in,
  input  logic            coef_valid,
  output logic            coef_ready,
  input  logic            inverse_in,
  output logic [Nb-1:0]   poly,
  output logic            data_in_ready,
  output logic            inverse,
  output logic            busy
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP - 1);

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t            state;
  logic [logN-1:0]   idx;
  logic [logN-1:0]   slot;
  logic [GAP_W-1:0]  gap_cnt;
  logic              first_frame;
  logic              frame_inv;
  logic [Nb-1:0]     shadow;
  logic [Nb-1:0]     shadow_next;
  logic [logP-1:0]   coef_mod;
  logic              xfer;
  logic              last;
  logic              gap_ok;
  logic              commit;

  assign coef_ready = (state == S_FILL) & ~reset;
  assign xfer       = coef_valid & coef_ready;
  assign last       = xfer & (idx == logN'(N - 1));
  assign gap_ok     = first_frame | (gap_cnt >= GAP_MAX);
  assign commit     = ((state == S_FILL) & last & gap_ok) | ((state == S_WAIT) & gap_ok);
  assign coef_mod   = logP'(coef_in % IN_W'(p));

  always_comb begin
    slot = '0;
    for (int i = 0; i < logN; i++)
      slot[i] = (BITREV != 0) ? idx[logN-1-i] : idx[i];
  end

  // The commit snapshot must include the coefficient landing on the same edge.
  always_comb begin
    shadow_next = shadow;
    if (xfer)
      shadow_next[slot*logP +: logP] = coef_mod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FILL;
      idx           <= '0;
      gap_cnt       <= '0;
      first_frame   <= 1'b1;
      frame_inv     <= 1'b0;
      shadow        <= '0;
      poly          <= '0;
      data_in_ready <= 1'b0;
      inverse       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_in_ready <= 1'b0;
      shadow        <= shadow_next;
      if (xfer) begin
        idx <= idx + 1'b1;
        if (idx == '0)
          frame_inv <= inverse_in;
      end
      if (commit) begin
        poly          <= shadow_next;
        inverse       <= frame_inv;
        data_in_ready <= 1'b1;
        first_frame   <= 1'b0;
        gap_cnt       <= '0;
      end else if (gap_cnt < GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      case (state)
        S_FILL:
          if (last && !gap_ok) begin
            state <= S_WAIT;
            busy  <= 1'b1;
          end
        S_WAIT:
          if (gap_ok) begin
            state <= S_FILL;
            busy  <= 1'b0;
          end
        default: begin
          state <= S_FILL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
